// File: rtl/encrypt_seq.sv
// Iterative PRESENT-80 encryption: one shared round and key-schedule stage, 4-phase req/ack front end.
// Optional build macro ENCRYPT_SEQ_ZEROISE_EN clears key-dependent state once each transaction completes.

module round (
    input  logic [63:0] state_in,
    input  logic [79:0] key_in,
    output logic [63:0] state_out
);
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    logic [63:0] mixed_s;
    logic [63:0] subst_s;

    // Add round key, substitute every nibble, then bit-permute (bit j -> 16*j mod 63, bit 63 fixed).
    always_comb begin
        mixed_s   = state_in ^ key_in[79:16];
        subst_s   = 64'd0;
        state_out = 64'd0;
        for (int n = 0; n < 16; n++) begin
            subst_s[4*n +: 4] = sbox(mixed_s[4*n +: 4]);
        end
        for (int j = 0; j < 63; j++) begin
            state_out[(j * 16) % 63] = subst_s[j];
        end
        state_out[63] = subst_s[63];
    end
endmodule

module key_schedule (
    input  logic [79:0] key_in,
    input  logic [4:0]  round_idx,
    output logic [79:0] key_out
);
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    logic [79:0] rot_s;

    // Rotate left by 61, substitute the top nibble, fold the round counter into bits 19..15.
    always_comb begin
        rot_s          = {key_in[18:0], key_in[79:19]};
        key_out        = rot_s;
        key_out[79:76] = sbox(rot_s[79:76]);
        key_out[19:15] = rot_s[19:15] ^ round_idx;
    end
endmodule

module key_addition (
    input  logic [63:0] state_in,
    input  logic [79:0] key_in,
    output logic [63:0] state_out
);
    assign state_out = state_in ^ key_in[79:16];
endmodule

module encrypt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    input  logic [79:0] k,
    input  logic [63:0] m,
    output logic [63:0] c
);
    localparam int N_K = 80;
    localparam int N_B = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [N_B-1:0] r_r;
    logic [N_K-1:0] key_r;
    logic [4:0]     i_r;
    logic           ack_r;
    logic [N_B-1:0] c_r;

    logic [N_B-1:0] round_out_s;
    logic [N_K-1:0] key_next_s;
    logic [N_B-1:0] whitened_s;

    round u_round (
        .state_in  (r_r),
        .key_in    (key_r),
        .state_out (round_out_s)
    );

    key_schedule u_key_schedule (
        .key_in    (key_r),
        .round_idx (i_r),
        .key_out   (key_next_s)
    );

    key_addition u_key_addition (
        .state_in  (r_r),
        .key_in    (key_r),
        .state_out (whitened_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a new capture needs req seen low in DONE first.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) next_state_s = RUN;
                else     next_state_s = IDLE;
            end
            RUN: begin
                if (i_r == 5'd31) next_state_s = FIN;
                else              next_state_s = RUN;
            end
            FIN:  next_state_s = DONE;
            DONE: begin
                if (!req) next_state_s = IDLE;
                else      next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath and handshake registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r   <= 64'd0;
            key_r <= 80'd0;
            i_r   <= 5'd0;
            ack_r <= 1'b0;
            c_r   <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        r_r   <= m;
                        key_r <= k;
                        i_r   <= 5'd1;
                    end
                end
                RUN: begin
                    r_r   <= round_out_s;
                    key_r <= key_next_s;
                    // Counter parks at 31 so it never wraps.
                    if (i_r != 5'd31) i_r <= i_r + 5'd1;
                end
                FIN: begin
                    c_r   <= whitened_s;
                    ack_r <= 1'b1;
`ifdef ENCRYPT_SEQ_ZEROISE_EN
                    r_r   <= 64'd0;
                    key_r <= 80'd0;
`endif
                end
                DONE: begin
                    if (!req) begin
                        ack_r <= 1'b0;
`ifdef ENCRYPT_SEQ_ZEROISE_EN
                        c_r   <= 64'd0;
`endif
                    end
                end
                default: begin
                    ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack = ack_r;
    assign c   = c_r;
endmodule

// File: tb/tb_encrypt_seq.sv
// Self-checking bench for encrypt_seq: a transaction-level PRESENT-80 model plus directed vectors.
module tb_encrypt_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [79:0] k;
    logic [63:0] m;
    logic        ack;
    logic [63:0] c;

    encrypt_seq dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .ack (ack),
        .k   (k),
        .m   (m),
        .c   (c)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Whole-block PRESENT-80 reference.
    function automatic logic [63:0] present80(input logic [79:0] key_in, input logic [63:0] pt);
        logic [79:0] kk;
        logic [63:0] s;
        logic [63:0] t;
        kk = key_in;
        s  = pt;
        for (int rnd = 1; rnd <= 31; rnd++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb[s[4*n +: 4]];
            for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : (b * 16) % 63] = t[b];
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sb[kk[79:76]];
            kk[19:15] = kk[19:15] ^ rnd[4:0];
        end
        return s ^ kk[79:16];
    endfunction

    logic        mdl_busy;
    logic        mdl_ack;
    int          mdl_cnt;
    logic [63:0] mdl_res;
    logic [63:0] mdl_c;

    // Protocol model: capture, 32 edges of work, then ack until req is seen low.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy <= 1'b0;
            mdl_ack  <= 1'b0;
            mdl_cnt  <= 0;
            mdl_res  <= 64'd0;
            mdl_c    <= 64'd0;
        end else if (mdl_busy) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 31) begin
                mdl_busy <= 1'b0;
                mdl_ack  <= 1'b1;
                mdl_c    <= mdl_res;
            end
        end else if (mdl_ack) begin
            if (!req) begin
                mdl_ack <= 1'b0;
`ifdef ENCRYPT_SEQ_ZEROISE_EN
                mdl_c   <= 64'd0;
`endif
            end
        end else if (req) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 0;
            mdl_res  <= present80(k, m);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("ack_cycle", {63'd0, ack}, {63'd0, mdl_ack});
            check("c_cycle", c, mdl_c);
        end
    end

    task automatic run_txn(input logic [79:0] kv, input logic [63:0] mv, input logic [63:0] lit,
                           input bit scramble, input int hold, input int drop_at);
        int n;
        bit got;
        logic [95:0] rnd96;
        @(negedge clk);
        k   = kv;
        m   = mv;
        req = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (drop_at > 0 && n == drop_at + 1) req = 1'b0;
            if (scramble) begin
                rnd96 = {$urandom(), $urandom(), $urandom()};
                k = rnd96[79:0];
                m = {$urandom(), $urandom()};
            end
            if (ack) got = 1'b1;
        end
        check("latency", 64'(n), 64'd33);
        check("ciphertext", c, lit);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            check("hold_ack", {63'd0, ack}, 64'd1);
            check("hold_c", c, lit);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        check("release_ack", {63'd0, ack}, 64'd0);
`ifdef ENCRYPT_SEQ_ZEROISE_EN
        check("release_c", c, 64'd0);
`else
        check("release_c", c, lit);
`endif
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        k   = 80'd0;
        m   = 64'd0;
        check("model_v0", present80(80'h0, 64'h0), 64'h5579C1387B228445);
        check("model_v1", present80({80{1'b1}}, 64'h0), 64'hE72C46C0F5945049);
        check("model_v2", present80(80'h0, {64{1'b1}}), 64'hA112FFC72F68417B);
        check("model_v3", present80({80{1'b1}}, {64{1'b1}}), 64'h3333DCD3213210D2);
        repeat (2) @(negedge clk);
        check("reset_ack", {63'd0, ack}, 64'd0);
        check("reset_c", c, 64'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run_txn(80'h0, 64'h0, 64'h5579C1387B228445, 1'b0, 0, 0);
        run_txn({80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 1'b0, 0, 0);
        run_txn(80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 1'b0, 0, 0);
        run_txn({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 1'b1, 0, 0);
        run_txn(80'h0, 64'h0, 64'h5579C1387B228445, 1'b0, 100, 0);

        // Abort at round 15: outputs clear at once, then a fresh request runs full length.
        @(negedge clk);
        k   = {80{1'b1}};
        m   = 64'h0;
        req = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("abort_ack", {63'd0, ack}, 64'd0);
        check("abort_c", c, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn({80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, 1'b0, 0, 0);

        run_txn(80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, 1'b0, 0, 10);
        run_txn({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/encrypt_seq.md
# encrypt_seq

Iterative, area-reduced PRESENT-80 encryption controller. It shares one `round` instance and one `key_schedule` instance across all 31 rounds, sequencing them with a round counter and state machine. The final whitening uses one `key_addition` instance. It is a drop-in alternative to the fully unrolled encryption datapath, fronted by a 4-phase req/ack handshake for the surrounding system or testbench.

## Interface
- No Verilog parameters.
- Widths come from `params.h`: `N_K` = 80, `N_B` = 64.
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — reset; asynchronous, active-high.
- `req`  input  1  — request, 4-phase handshake.
- `ack`  output  1  — acknowledge, registered.
- `k`  input  `N_K`  — cipher key; sampled only at the capture edge.
- `m`  input  `N_B`  — plaintext; sampled only at the capture edge.
- `c`  output  `N_B`  — ciphertext, registered; valid while `ack`=1.

## Operation
- Internal registers:
  - `r` (64-bit) — round state.
  - `key` (80-bit) — round key.
  - `i` (5-bit) — round counter.
  - `state` — one of IDLE, RUN, FIN, DONE.
- IDLE:
  - `ack`=0.
  - If `req`=1 is sampled: `r`<=`m`, `key`<=`k`, `i`<=1, go to RUN (capture edge E0).
- RUN:
  - Each edge: `r`<=round(`r`,`key`), `key`<=key_schedule(`key`,`i`), `i`<=`i`+1.
  - On the edge where `i`==31: go to FIN. No 5-bit wrap is ever reached.
- FIN:
  - `c`<=key_addition(`r`,`key`), `ack`<=1, go to DONE.
- DONE:
  - Hold `c`, hold `ack`=1 while `req`=1.
  - When `req`=0 is sampled: `ack`<=0, go to IDLE.
- A 4-phase cycle is enforced by design: a new request is accepted only after `req` has been seen low in DONE.
- Protocol violations:
  - `req` deasserted during RUN/FIN is ignored; the computation completes, `ack` pulses high for one cycle in DONE, then returns to IDLE.
  - `k`/`m` changes after E0 have no effect.
- Reset mid-operation: the computation is aborted immediately. All registers return to reset values; no partial `c` is exposed.

## Timing
- Reset values: `ack`=0, `c`=0, `r`=0, `key`=0, `i`=0, `state`=IDLE.
- Round edges: E1..E31 perform rounds 1..31. E32 (FIN) loads `c` and sets `ack`.
- `ack` is visible high after E32, i.e. 32 cycles after the capture edge and 33 cycles after `req` rises if it rises mid-cycle before E0.
- `ack` falls on the first edge at which `req`=0 is sampled in DONE.
- Minimum full transaction: 34 edges (capture, 31 rounds, FIN, release).
- Throughput: one block per ≥34 cycles.
- Critical path: one round plus one key_schedule plus mux, replacing 31 chained rounds.

## Configuration
- Macro: `ENCRYPT_SEQ_ZEROISE_EN`.
- When defined:
  - At E32, `r` and `key` are cleared to 0 in the same edge that loads `c`.
  - On the DONE→IDLE edge, `c` is cleared to 0.
  - No key-dependent state persists outside an active transaction.
- When undefined: `r`/`key` retain their final values, and `c` holds its value until the next FIN or reset.
- Handshake timing is identical in both builds.

## Test plan
- `k`=0x00000000000000000000, `m`=0x0000000000000000, `req`↑ → `ack`↑ 32 cycles after capture, `c`=0x5579C1387B228445. `req`↓ → `ack`↓ next edge.
- `k`=0xFFFFFFFFFFFFFFFFFFFF, `m`=0x0000000000000000 → `c`=0xE72C46C0F5945049. Also `k`=0, `m`=0xFFFFFFFFFFFFFFFF → `c`=0xA112FFC72F68417B.
- `k`=all-ones, `m`=all-ones → `c`=0x3333DCD3213210D2. Change `k`/`m` randomly every cycle after E0 → result unchanged.
- Hold `req`=1 for 100 cycles after `ack`↑ → `ack` stays 1 and `c` stable, with no second capture. Back-to-back transactions → each matches its own vector.
- Assert `rst` at round 15 → `ack`=0 and `c`=0 immediately. A new request then gives the correct vector with full 32-cycle latency.
- Drop `req` at round 10 → `ack` high for exactly one cycle after E32, then IDLE. With `ENCRYPT_SEQ_ZEROISE_EN`, `c`=0 after `ack`↓; without it, `c` holds the ciphertext.
